titles_seq_ctrl: RTL
====================

// Module: titles_seq_ctrl
// PURPOSE
//  Sequences which HUD titles (high score, score, credit, lives) are visible. Produces
//  per-title enable gates ANDed with each title's DR ahead of the titles priority mux.
//  Frame-paced FSM: attract (IDLE) -> PLAY -> OVER -> IDLE, with credit blink in attract
//  and a timed lives flash after a life is lost. All timing counts frames, not clocks.
// PARAMETERS
//  BLINK_FRAMES  30   frames per credit blink half-period (on or off) in IDLE
//  FLASH_FRAMES  64   total lives-flash duration in PLAY after a life is lost
//  FLASH_HALF    8    frames per lives-flash half-period (on or off)
//  OVER_FRAMES   180  frames OVER is held before returning to IDLE
//  CNT_W         8    width of frame counters; every *_FRAMES value must be < 2**CNT_W
// PORTS
//  clk           in   1      system clock
//  reset         in   1      asynchronous, active-high reset
//  startOfFrame  in   1      1-clk pulse, once per video frame
//  gameStart     in   1      1-clk pulse: player pressed start
//  gameOver      in   1      1-clk pulse: last life gone / invaders landed
//  creditIn      in   1      1-clk pulse: credit inserted
//  lifeLost      in   1      1-clk pulse: player hit, lives > 0 remain
//  highEn        out  1      gate for high-score title
//  scoreEn       out  1      gate for score title
//  creditEn      out  1      gate for credit title
//  livesEn       out  1      gate for lives title
//  seqState      out  2      current state: 0 IDLE, 1 PLAY, 2 OVER (3 unused)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, all frame counters=0, blink phase=on, flash
//   inactive, all *En=0, seqState=0. First enables appear 1 clk after reset release.
//  All outputs registered; each reflects state/counters of the previous cycle (1-clk latency).
//  Counters advance only on clocks where startOfFrame=1; other events act on any clock.
//  IDLE: highEn=1, scoreEn=0, livesEn=0, creditEn=blink phase.
//   Blink counter counts frames 0..BLINK_FRAMES-1; at wrap toggles phase, counter->0.
//   creditIn: blink counter->0, phase->on (credit shown immediately, full half-period).
//   gameStart -> PLAY; gameOver ignored.
//  PLAY: highEn=scoreEn=creditEn=1; livesEn=1 unless flash active and flash phase=off.
//   lifeLost: flash active, flash counter->0, phase->off (restarts if already flashing).
//   Flash phase toggles every FLASH_HALF frames; flash ends when counter reaches
//   FLASH_FRAMES-1 on a frame tick; on end livesEn=1, phase forced on.
//   gameOver -> OVER, aborts flash; gameStart ignored; creditIn no effect on sequencing.
//  OVER: highEn=scoreEn=1, creditEn=livesEn=0. Over counter counts frames from 0;
//   when it reaches OVER_FRAMES-1 on a frame tick -> IDLE with blink counter 0, phase on.
//   gameStart in OVER -> PLAY immediately (skip remaining hold); lifeLost ignored.
//  On every state entry the entered state's counter clears to 0.
//  Simultaneous events, same clk: gameOver beats gameStart and lifeLost (in PLAY);
//   event pulse coinciding with startOfFrame: event applied, counter restarts at 0 (tick
//   not counted). gameStart+creditIn in IDLE: PLAY taken, creditIn discarded.
//  Counter overflow impossible: counters are compared for equality and cleared at limit.
//  Reset asserted mid-flash or mid-OVER: returns to reset values, no residual pulses.
// TESTING
//  T1 reset high 5 clks, release -> next clk highEn=1, creditEn=1, scoreEn=livesEn=0, seqState=0.
//  T2 IDLE, 30 frame ticks -> creditEn 1->0 one clk after 30th tick; 30 more -> 1; creditIn
//     mid-off-phase -> creditEn=1 next clk, stays 1 for next 30 ticks.
//  T3 gameStart -> seqState=1, all four En=1; lifeLost -> livesEn=0 for 8 ticks, 1 for 8,
//     ... ends after 64 ticks with livesEn=1; second lifeLost at tick 20 restarts 64-tick flash.
//  T4 PLAY + gameOver and gameStart same clk -> seqState=2, creditEn=livesEn=0; after
//     180 ticks -> seqState=0, creditEn=1.
//  T5 OVER at tick 50, gameStart -> seqState=1 next clk, all En=1, flash inactive.
//  T6 reset asserted during lives flash -> all En=0 within same cycle, seqState=0.

Source files
------------

// File: rtl/titles_seq_ctrl.sv
// HUD titles sequencer: gates the high-score, score, credit and lives titles
// according to an attract -> play -> game-over flow paced by video frames.
// Credit blinks in attract; lives flash for a fixed time after a life is lost.
module titles_seq_ctrl #(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned FLASH_FRAMES = 64,
  parameter int unsigned FLASH_HALF   = 8,
  parameter int unsigned OVER_FRAMES  = 180,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       gameStart,
  input  logic       gameOver,
  input  logic       creditIn,
  input  logic       lifeLost,
  output logic       highEn,
  output logic       scoreEn,
  output logic       creditEn,
  output logic       livesEn,
  output logic [1:0] seqState
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Terminal counts; counters are compared for equality and cleared there,
  // so they never wrap through zero on their own.
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] blink_cnt_q;
  logic             blink_on_q;
  logic [CNT_W-1:0] flash_cnt_q;
  logic [CNT_W-1:0] flash_half_q;
  logic             flash_act_q;
  logic             flash_on_q;
  logic [CNT_W-1:0] over_cnt_q;
  logic             high_en_q;
  logic             score_en_q;
  logic             credit_en_q;
  logic             lives_en_q;
  logic [1:0]       seq_state_q;

  // Sequencer FSM with its frame counters; the enables are registered from the
  // state held at the start of the cycle, giving a uniform one-clock latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      blink_cnt_q  <= CNT_ZERO;
      blink_on_q   <= 1'b1;
      flash_cnt_q  <= CNT_ZERO;
      flash_half_q <= CNT_ZERO;
      flash_act_q  <= 1'b0;
      flash_on_q   <= 1'b1;
      over_cnt_q   <= CNT_ZERO;
      high_en_q    <= 1'b0;
      score_en_q   <= 1'b0;
      credit_en_q  <= 1'b0;
      lives_en_q   <= 1'b0;
      seq_state_q  <= 2'd0;
    end else begin
      // Title gates derived from the current (pre-update) state.
      case (state_q)
        ST_IDLE: begin
          high_en_q   <= 1'b1;
          score_en_q  <= 1'b0;
          credit_en_q <= blink_on_q;
          lives_en_q  <= 1'b0;
        end
        ST_PLAY: begin
          high_en_q   <= 1'b1;
          score_en_q  <= 1'b1;
          credit_en_q <= 1'b1;
          lives_en_q  <= ~flash_act_q | flash_on_q;
        end
        ST_OVER: begin
          high_en_q   <= 1'b1;
          score_en_q  <= 1'b1;
          credit_en_q <= 1'b0;
          lives_en_q  <= 1'b0;
        end
        default: begin
          high_en_q   <= 1'b0;
          score_en_q  <= 1'b0;
          credit_en_q <= 1'b0;
          lives_en_q  <= 1'b0;
        end
      endcase
      seq_state_q <= state_q;

      // State transitions; events take priority over the frame tick, so an
      // event on a tick cycle restarts its counter at zero without counting.
      case (state_q)
        ST_IDLE: begin
          if (gameStart) begin
            // creditIn on the same clock is dropped: the game has started.
            state_q      <= ST_PLAY;
            flash_cnt_q  <= CNT_ZERO;
            flash_half_q <= CNT_ZERO;
            flash_act_q  <= 1'b0;
            flash_on_q   <= 1'b1;
          end else if (creditIn) begin
            // Show the credit at once for a full on half-period.
            blink_cnt_q <= CNT_ZERO;
            blink_on_q  <= 1'b1;
          end else if (startOfFrame) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_q <= CNT_ZERO;
              blink_on_q  <= ~blink_on_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + CNT_ONE;
            end
          end else begin
            blink_cnt_q <= blink_cnt_q;
          end
        end
        ST_PLAY: begin
          if (gameOver) begin
            state_q      <= ST_OVER;
            over_cnt_q   <= CNT_ZERO;
            flash_cnt_q  <= CNT_ZERO;
            flash_half_q <= CNT_ZERO;
            flash_act_q  <= 1'b0;
            flash_on_q   <= 1'b1;
          end else if (lifeLost) begin
            // Start (or restart) the lives flash in its dark phase.
            flash_cnt_q  <= CNT_ZERO;
            flash_half_q <= CNT_ZERO;
            flash_act_q  <= 1'b1;
            flash_on_q   <= 1'b0;
          end else if (startOfFrame && flash_act_q) begin
            if (flash_cnt_q == FLASH_LAST) begin
              flash_cnt_q  <= CNT_ZERO;
              flash_half_q <= CNT_ZERO;
              flash_act_q  <= 1'b0;
              flash_on_q   <= 1'b1;
            end else begin
              flash_cnt_q <= flash_cnt_q + CNT_ONE;
              if (flash_half_q == HALF_LAST) begin
                flash_half_q <= CNT_ZERO;
                flash_on_q   <= ~flash_on_q;
              end else begin
                flash_half_q <= flash_half_q + CNT_ONE;
              end
            end
          end else begin
            flash_cnt_q <= flash_cnt_q;
          end
        end
        ST_OVER: begin
          if (gameStart) begin
            // Skip the remaining hold and go straight back into play.
            state_q      <= ST_PLAY;
            flash_cnt_q  <= CNT_ZERO;
            flash_half_q <= CNT_ZERO;
            flash_act_q  <= 1'b0;
            flash_on_q   <= 1'b1;
          end else if (startOfFrame) begin
            if (over_cnt_q == OVER_LAST) begin
              state_q     <= ST_IDLE;
              over_cnt_q  <= CNT_ZERO;
              blink_cnt_q <= CNT_ZERO;
              blink_on_q  <= 1'b1;
            end else begin
              over_cnt_q <= over_cnt_q + CNT_ONE;
            end
          end else begin
            over_cnt_q <= over_cnt_q;
          end
        end
        default: begin
          // Unused encoding: recover to attract with everything cleared.
          state_q      <= ST_IDLE;
          blink_cnt_q  <= CNT_ZERO;
          blink_on_q   <= 1'b1;
          flash_cnt_q  <= CNT_ZERO;
          flash_half_q <= CNT_ZERO;
          flash_act_q  <= 1'b0;
          flash_on_q   <= 1'b1;
          over_cnt_q   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign highEn   = high_en_q;
  assign scoreEn  = score_en_q;
  assign creditEn = credit_en_q;
  assign livesEn  = lives_en_q;
  assign seqState = seq_state_q;

endmodule
